dec_hazard_ctrl: RTL and testbench
==================================

// Module: dec_hazard_ctrl
// PURPOSE
//   Pipeline control initiator for the decode->ALU buffer. Drives the enable and
//   bubble-insertion (flush) inputs of the fetch/decode and decode/ALU buffers,
//   and the PC enable. Detects load-use hazards against the instruction held in
//   the ALU stage and sequences interrupt entry: drain, PC push, then vector fetch.
// PARAMETERS
//   REG_W        3  register address width
//   DRAIN_CYC    3  bubble cycles inserted before the PC push on interrupt entry (1..15)
//   VEC_CYC      2  cycles PC is steered to the interrupt vector (1..15)
// PORTS
//   clk           in   1      clock; all state updates on posedge
//   rst           in   1      asynchronous, active-high reset
//   id_Rsrc1      in   REG_W  source reg 1 of instruction in decode
//   id_Rsrc2      in   REG_W  source reg 2 of instruction in decode
//   id_use1       in   1      decode instruction reads Rsrc1
//   id_use2       in   1      decode instruction reads Rsrc2
//   ex_mem_read   in   1      ALU-stage instruction is a load (Mem ctrl bit)
//   ex_wb_en      in   1      ALU-stage instruction writes back
//   ex_Rdst       in   REG_W  ALU-stage destination reg
//   in_INT        in   1      external interrupt request (level, edge-detected)
//   o_pc_en       out  1      PC register enable
//   o_fd_en       out  1      fetch/decode buffer enable
//   o_fd_flush    out  1      fetch/decode buffer loads NOP
//   o_de_en       out  1      decode/ALU buffer enable
//   o_de_flush    out  1      decode/ALU buffer loads bubble (all ctrl fields 0)
//   o_int_push    out  1      one-cycle pulse: memory stage pushes PC and flags
//   o_pc_vec_sel  out  1      PC mux selects the interrupt vector path
//   o_int_ack     out  1      one-cycle pulse at the end of interrupt entry
// BEHAVIOUR
//   - State regs: st{IDLE,DRAIN,PUSH,VEC}, cnt[3:0], int_d (prev in_INT), pend.
//   - rst=1 (async): st=IDLE, cnt=0, int_d=0, pend=0. While rst=1: o_pc_en=0,
//     o_fd_en=0, o_de_en=1, o_de_flush=1, o_fd_flush=1, all pulses/selects 0.
//   - Outputs are combinational from state and inputs; zero-cycle hazard response.
//   - luh = ex_mem_read & ex_wb_en & ((id_use1 & id_Rsrc1==ex_Rdst) |
//     (id_use2 & id_Rsrc2==ex_Rdst)). Register 0 is not special.
//   - Edge: rise = in_INT & ~int_d. On rise, pend<=1 in any state. One-deep:
//     further rises while pend=1 are dropped. pend clears on entry to DRAIN.
//   - IDLE, luh=1: o_pc_en=0, o_fd_en=0, o_de_en=1, o_de_flush=1; stays IDLE.
//     Exactly one bubble per hazard (load advances next cycle).
//   - IDLE, luh=0, no pending request: all enables 1, flushes 0.
//   - IDLE, luh=0, pend=1 (or rise this cycle): outputs as no-hazard IDLE;
//     next st=DRAIN, cnt<=DRAIN_CYC-1. luh takes priority; INT entry is deferred.
//   - DRAIN: o_pc_en=0, o_fd_en=0, o_de_en=1, o_de_flush=1; cnt-- per cycle;
//     at cnt==0 -> PUSH. DRAIN lasts exactly DRAIN_CYC cycles.
//   - PUSH (1 cycle): o_int_push=1, o_pc_en=0, o_fd_en=0, o_de_flush=1;
//     -> VEC, cnt<=VEC_CYC-1.
//   - VEC: o_pc_vec_sel=1, o_pc_en=1, o_fd_en=1, o_fd_flush=1, o_de_flush=1;
//     cnt--; at cnt==0: o_int_ack=1 that cycle, -> IDLE.
//   - luh is ignored outside IDLE: the pipe is already bubbled.
//   - A request pending on return to IDLE starts a new entry on the next cycle.
//   - Reset mid-sequence aborts immediately; a pending request is lost.
//   - Total entry latency: rise in cycle N -> o_int_ack in cycle
//     N+1+DRAIN_CYC+1+VEC_CYC-1 (no luh).
// TESTING
//   1. Reset: rst=1 async mid-cycle -> o_pc_en=0, o_de_flush=1 at once;
//      release -> IDLE, all enables 1.
//   2. Load-use: ex_mem_read=1, ex_wb_en=1, ex_Rdst=3, id_Rsrc2=3, id_use2=1
//      -> one cycle o_pc_en=0, o_de_flush=1; clear inputs -> enables 1.
//   3. No hazard: same as 2 with id_use2=0, or ex_wb_en=0 -> no stall.
//   4. INT defaults: in_INT 0->1 at cycle 0 -> DRAIN cycles 1-3,
//      o_int_push at 4, o_pc_vec_sel at 5-6, o_int_ack at 6.
//   5. INT + luh in the same IDLE cycle -> bubble first; DRAIN starts
//      next cycle; ack one cycle later than 4.
//   6. Second rise during DRAIN -> serviced after return to IDLE. Third rise
//      while pending -> dropped. rst during VEC -> IDLE; no ack, no re-entry.

Source files
------------

// File: rtl/dec_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dec_hazard_ctrl
// Brief   : Decode-stage pipeline control: load-use bubbles and interrupt entry.
// Revision: 1.0 - initial release
// ============================================================================
module dec_hazard_ctrl #(
    parameter int REG_W     = 3,
    parameter int DRAIN_CYC = 3,
    parameter int VEC_CYC   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_Rsrc1,
    input  logic [REG_W-1:0] id_Rsrc2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic             ex_mem_read,
    input  logic             ex_wb_en,
    input  logic [REG_W-1:0] ex_Rdst,
    input  logic             in_INT,
    output logic             o_pc_en,
    output logic             o_fd_en,
    output logic             o_fd_flush,
    output logic             o_de_en,
    output logic             o_de_flush,
    output logic             o_int_push,
    output logic             o_pc_vec_sel,
    output logic             o_int_ack
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_PUSH  = 2'd2,
        ST_VEC   = 2'd3
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYC - 1);
    localparam logic [3:0] VEC_LOAD   = 4'(VEC_CYC - 1);

    state_t     st_q, st_d;
    logic [3:0] cnt_q, cnt_d;
    logic       int_q;
    logic       pend_q, pend_d;
    logic       luh;
    logic       rise;

    assign luh  = ex_mem_read & ex_wb_en &
                  ((id_use1 & (id_Rsrc1 == ex_Rdst)) |
                   (id_use2 & (id_Rsrc2 == ex_Rdst)));
    assign rise = in_INT & ~int_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= ST_IDLE;
            cnt_q  <= 4'd0;
            int_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            int_q  <= in_INT;
            pend_q <= pend_d;
        end
    end

    always_comb begin
        st_d         = st_q;
        cnt_d        = cnt_q;
        // One-deep request latch: a rise while already pending is absorbed.
        pend_d       = pend_q | rise;
        o_pc_en      = 1'b1;
        o_fd_en      = 1'b1;
        o_fd_flush   = 1'b0;
        o_de_en      = 1'b1;
        o_de_flush   = 1'b0;
        o_int_push   = 1'b0;
        o_pc_vec_sel = 1'b0;
        o_int_ack    = 1'b0;

        case (st_q)
            ST_IDLE: begin
                if (luh) begin
                    o_pc_en    = 1'b0;
                    o_fd_en    = 1'b0;
                    o_de_flush = 1'b1;
                end else if (pend_q | rise) begin
                    st_d   = ST_DRAIN;
                    cnt_d  = DRAIN_LOAD;
                    pend_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                o_pc_en    = 1'b0;
                o_fd_en    = 1'b0;
                o_de_flush = 1'b1;
                if (cnt_q == 4'd0) begin
                    st_d = ST_PUSH;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_PUSH: begin
                o_pc_en    = 1'b0;
                o_fd_en    = 1'b0;
                o_de_flush = 1'b1;
                o_int_push = 1'b1;
                st_d       = ST_VEC;
                cnt_d      = VEC_LOAD;
            end
            ST_VEC: begin
                o_pc_vec_sel = 1'b1;
                o_fd_flush   = 1'b1;
                o_de_flush   = 1'b1;
                if (cnt_q == 4'd0) begin
                    o_int_ack = 1'b1;
                    st_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: st_d = ST_IDLE;
        endcase

        // Reset freezes the front end and bubbles both buffers immediately.
        if (rst) begin
            o_pc_en      = 1'b0;
            o_fd_en      = 1'b0;
            o_fd_flush   = 1'b1;
            o_de_en      = 1'b1;
            o_de_flush   = 1'b1;
            o_int_push   = 1'b0;
            o_pc_vec_sel = 1'b0;
            o_int_ack    = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dec_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_dec_hazard_ctrl
// Brief   : Directed vector bench for dec_hazard_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dec_hazard_ctrl;

    // Output vector order: {pc_en, fd_en, fd_flush, de_en, de_flush, int_push, vec_sel, int_ack}
    localparam logic [7:0] C_RST  = 8'b0011_1000;
    localparam logic [7:0] C_NORM = 8'b1101_0000;
    localparam logic [7:0] C_BUB  = 8'b0001_1000;
    localparam logic [7:0] C_PUSH = 8'b0001_1100;
    localparam logic [7:0] C_VEC  = 8'b1111_1010;
    localparam logic [7:0] C_ACK  = 8'b1111_1011;

    logic       clk, rst;
    logic [2:0] id_Rsrc1, id_Rsrc2, ex_Rdst;
    logic       id_use1, id_use2, ex_mem_read, ex_wb_en, in_INT;
    logic       o_pc_en, o_fd_en, o_fd_flush, o_de_en, o_de_flush;
    logic       o_int_push, o_pc_vec_sel, o_int_ack;
    logic [7:0] outs;

    int n_checks = 0;
    int n_fails  = 0;

    dec_hazard_ctrl #(.REG_W(3), .DRAIN_CYC(3), .VEC_CYC(2)) dut (
        .clk(clk), .rst(rst),
        .id_Rsrc1(id_Rsrc1), .id_Rsrc2(id_Rsrc2),
        .id_use1(id_use1), .id_use2(id_use2),
        .ex_mem_read(ex_mem_read), .ex_wb_en(ex_wb_en), .ex_Rdst(ex_Rdst),
        .in_INT(in_INT),
        .o_pc_en(o_pc_en), .o_fd_en(o_fd_en), .o_fd_flush(o_fd_flush),
        .o_de_en(o_de_en), .o_de_flush(o_de_flush), .o_int_push(o_int_push),
        .o_pc_vec_sel(o_pc_vec_sel), .o_int_ack(o_int_ack)
    );

    assign outs = {o_pc_en, o_fd_en, o_fd_flush, o_de_en, o_de_flush,
                   o_int_push, o_pc_vec_sel, o_int_ack};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic       u1;
        logic       u2;
        logic       mr;
        logic       wb;
        logic [2:0] rd;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[10];

    task automatic check(input string nm, input logic [7:0] exp);
        n_checks++;
        if (outs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %b expected %b", nm, outs, exp);
        end
    endtask

    // Check at the falling edge, then advance to 1 time unit after the next rising edge.
    task automatic cyc(input string nm, input logic [7:0] exp);
        @(negedge clk);
        check(nm, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hz();
        id_Rsrc1 = 3'd0; id_Rsrc2 = 3'd0; id_use1 = 1'b0; id_use2 = 1'b0;
        ex_mem_read = 1'b0; ex_wb_en = 1'b0; ex_Rdst = 3'd0;
    endtask

    initial begin
        vt[0] = '{3'd0, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, C_BUB};
        vt[1] = '{3'd0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, C_NORM};
        vt[2] = '{3'd0, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, C_NORM};
        vt[3] = '{3'd0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, C_NORM};
        vt[4] = '{3'd3, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, C_BUB};
        vt[5] = '{3'd5, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5, C_BUB};
        vt[6] = '{3'd0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, C_BUB};
        vt[7] = '{3'd7, 3'd6, 1'b1, 1'b1, 1'b1, 1'b1, 3'd5, C_NORM};
        vt[8] = '{3'd7, 3'd7, 1'b0, 1'b0, 1'b1, 1'b1, 3'd7, C_NORM};
        vt[9] = '{3'd6, 3'd6, 1'b1, 1'b1, 1'b1, 1'b1, 3'd6, C_BUB};

        rst = 1'b1; in_INT = 1'b0;
        clear_hz();
        #3;
        check("reset_hold", C_RST);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        cyc("reset_release", C_NORM);

        // Load-use vectors, each applied for a single cycle from IDLE.
        for (int i = 0; i < 10; i++) begin
            id_Rsrc1 = vt[i].rs1; id_Rsrc2 = vt[i].rs2;
            id_use1  = vt[i].u1;  id_use2  = vt[i].u2;
            ex_mem_read = vt[i].mr; ex_wb_en = vt[i].wb; ex_Rdst = vt[i].rd;
            cyc($sformatf("luh_vec%0d", i), vt[i].exp);
            clear_hz();
            cyc($sformatf("luh_after%0d", i), C_NORM);
        end

        // Interrupt entry with default timing.
        in_INT = 1'b1;
        cyc("int_c0", C_NORM);
        cyc("int_drain1", C_BUB);
        cyc("int_drain2", C_BUB);
        cyc("int_drain3", C_BUB);
        cyc("int_push", C_PUSH);
        cyc("int_vec1", C_VEC);
        cyc("int_ack", C_ACK);
        in_INT = 1'b0;
        cyc("int_idle1", C_NORM);
        cyc("int_idle2", C_NORM);

        // Interrupt rise coinciding with a load-use hazard.
        ex_mem_read = 1'b1; ex_wb_en = 1'b1; ex_Rdst = 3'd3;
        id_Rsrc2 = 3'd3; id_use2 = 1'b1; in_INT = 1'b1;
        cyc("intluh_bubble", C_BUB);
        clear_hz();
        cyc("intluh_idle", C_NORM);
        cyc("intluh_drain1", C_BUB);
        cyc("intluh_drain2", C_BUB);
        cyc("intluh_drain3", C_BUB);
        cyc("intluh_push", C_PUSH);
        cyc("intluh_vec1", C_VEC);
        cyc("intluh_ack", C_ACK);
        in_INT = 1'b0;
        cyc("intluh_idle2", C_NORM);

        // Second rise during DRAIN is queued; third rise while pending is dropped.
        in_INT = 1'b1;
        cyc("dbl_c0", C_NORM);
        in_INT = 1'b0;
        cyc("dbl_drain1", C_BUB);
        in_INT = 1'b1;
        cyc("dbl_drain2", C_BUB);
        in_INT = 1'b0;
        cyc("dbl_drain3", C_BUB);
        in_INT = 1'b1;
        cyc("dbl_push", C_PUSH);
        in_INT = 1'b0;
        cyc("dbl_vec1", C_VEC);
        cyc("dbl_ack", C_ACK);
        cyc("dbl_idle", C_NORM);
        cyc("dbl2_drain1", C_BUB);
        cyc("dbl2_drain2", C_BUB);
        cyc("dbl2_drain3", C_BUB);
        cyc("dbl2_push", C_PUSH);
        cyc("dbl2_vec1", C_VEC);
        cyc("dbl2_ack", C_ACK);
        cyc("dbl2_idle1", C_NORM);
        cyc("dbl2_idle2", C_NORM);

        // Short reset pulse inside VEC, with a request pending that must be lost.
        in_INT = 1'b1;
        cyc("rv_c0", C_NORM);
        in_INT = 1'b0;
        cyc("rv_drain1", C_BUB);
        cyc("rv_drain2", C_BUB);
        cyc("rv_drain3", C_BUB);
        in_INT = 1'b1;
        cyc("rv_push", C_PUSH);
        in_INT = 1'b0;
        @(negedge clk);
        check("rv_vec1", C_VEC);
        #1 rst = 1'b1;
        #1 check("rv_rst_async", C_RST);
        #1 rst = 1'b0;
        #1 check("rv_after_pulse", C_NORM);
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin
            cyc($sformatf("rv_quiet%0d", k), C_NORM);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
